// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: column-input handshake and memory write bus of the result drain.
// slave is the drain's own view; master is the array/memory side driving it.
interface systolic_result_drain_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 12
);
    logic                    col_valid;
    logic                    col_ready;
    logic [N-1:0][WIDTH-1:0] col_data;   // slice i holds row i of the column
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic signed [WIDTH-1:0] mem_data_write;
    logic                    mem_ready;

    modport master (
        output col_valid, col_data, mem_ready,
        input  col_ready, mem_write, mem_addr, mem_data_write
    );

    modport slave (
        input  col_valid, col_data, mem_ready,
        output col_ready, mem_write, mem_addr, mem_data_write
    );
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: buffers N-wide result columns in a small FIFO and serialises them
// into single-word writes forming matrix C row-major at a latched base address.
// Optional macro DRAIN_STALL_CNT_EN adds a saturating count of back-pressured request cycles.
module systolic_result_drain #(
    parameter int unsigned N      = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     addr_c_i,
    input  logic [3:0]            n_i,
    systolic_result_drain_if.slave bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           stall_cycles_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  NMax = 4'(N);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [3:0]              nn_q, nn_d;
    logic [3:0]              cols_in_q, cols_in_d;  // columns accepted this job
    logic [3:0]              col_out_q, col_out_d;  // column index j of the FIFO head
    logic [3:0]              elem_q, elem_d;        // element index i within the head
    logic [7:0]              words_q, words_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]           count_q, count_d;
    logic [N-1:0][WIDTH-1:0] fifo_mem_q [DEPTH];

    logic                    fifo_empty, fifo_full, push, wr_fire, pop, last_word;
    logic [7:0]              total_words;
    logic [3:0]              nn_start;
    logic [N-1:0][WIDTH-1:0] head;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (PtrW + 1)'(DEPTH));
    assign total_words = 8'(nn_q) * 8'(nn_q);
    assign nn_start    = (n_i > NMax) ? NMax : n_i;
    assign head        = fifo_mem_q[rd_ptr_q];

    // Handshake outputs depend on registered state only
    always_comb begin
        bus.col_ready      = (state_q == StDrain) && !fifo_full && (cols_in_q < nn_q);
        bus.mem_write      = (state_q == StDrain) && !fifo_empty;
        bus.mem_addr       = '0;
        bus.mem_data_write = '0;
        if (bus.mem_write) begin
            bus.mem_addr = base_q + ADDR_W'(elem_q) * ADDR_W'(nn_q) + ADDR_W'(col_out_q);
            for (int k = 0; k < N; k++) begin
                if (elem_q == 4'(k)) bus.mem_data_write = $signed(head[k]);
            end
        end
    end

    assign push      = bus.col_valid && bus.col_ready;
    assign wr_fire   = bus.mem_write && bus.mem_ready;
    assign pop       = wr_fire && (elem_q == nn_q - 4'd1);
    assign last_word = wr_fire && (words_q == total_words - 8'd1);
    assign busy_o    = (state_q == StDrain);
    assign done_o    = (state_q == StDone);

    // Next-state: job control, FIFO pointers and write sequencing
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nn_d      = nn_q;
        cols_in_d = cols_in_q;
        col_out_d = col_out_q;
        elem_d    = elem_q;
        words_d   = words_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d    = addr_c_i;
                    nn_d      = nn_start;
                    cols_in_d = '0;
                    col_out_d = '0;
                    elem_d    = '0;
                    words_d   = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    count_d   = '0;
                    state_d   = (nn_start == '0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (push) begin
                    wr_ptr_d  = wr_ptr_q + PtrW'(1);
                    cols_in_d = cols_in_q + 4'd1;
                end
                if (wr_fire) begin
                    words_d = words_q + 8'd1;
                    if (pop) begin
                        elem_d    = '0;
                        col_out_d = col_out_q + 4'd1;
                        rd_ptr_d  = rd_ptr_q + PtrW'(1);
                    end else begin
                        elem_d = elem_q + 4'd1;
                    end
                end
                count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
                if (last_word) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= '0;
            nn_q      <= '0;
            cols_in_q <= '0;
            col_out_q <= '0;
            elem_q    <= '0;
            words_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            nn_q      <= nn_d;
            cols_in_q <= cols_in_d;
            col_out_q <= col_out_d;
            elem_q    <= elem_d;
            words_q   <= words_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Column storage; contents are don't-care once the pointers reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.col_data;
    end

`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles a request waits on the memory
    always_comb begin
        stall_d = stall_q;
        if ((state_q == StIdle) && start_i) begin
            stall_d = '0;
        end else if (bus.mem_write && !bus.mem_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized scoreboard bench for systolic_result_drain.
// Expected writes are generated per job from the row-major address rule and checked by a
// monitor whenever a write is accepted.
module tb_systolic_result_drain;
    localparam int unsigned N      = 4;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] addr_c;
    logic [3:0]  n;
    logic        busy, done;
    logic [15:0] stall_cycles;

    systolic_result_drain_if #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    systolic_result_drain #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .addr_c_i       (addr_c),
        .n_i            (n),
        .bus            (bus.slave),
        .busy_o         (busy),
        .done_o         (done),
        .stall_cycles_o (stall_cycles)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    word_t exp_q[$];
    int    cols_acc, writes, done_cnt, stall_exp, last_evt;
    int    ready_mode = 0;

    logic [15:0] feed_cols [N][N];
    int          feed_nn;
    bit          feed_gaps, feed_go = 1'b0, feed_abort = 1'b0, feed_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory ready pattern
    initial begin
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.mem_ready = 1'b1;
                1:       bus.mem_ready = ~bus.mem_ready;
                2:       bus.mem_ready = 1'($urandom_range(1));
                default: bus.mem_ready = 1'b0;
            endcase
        end
    end

    // Column feeder: offers feed_cols in order, then holds junk valid to probe col_ready
    initial begin
        bit acc;
        int tmo;
        bus.col_valid = 1'b0;
        bus.col_data  = '0;
        feed_done     = 1'b1;
        forever begin
            wait (feed_go);
            feed_go   = 1'b0;
            feed_done = 1'b0;
            for (int j = 0; j < feed_nn; j++) begin
                if (feed_abort) break;
                if (feed_gaps && ($urandom_range(3) == 0)) begin
                    bus.col_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                bus.col_valid = 1'b1;
                for (int i = 0; i < N; i++) bus.col_data[i] = feed_cols[j][i];
                acc = 1'b0;
                tmo = 0;
                while (!acc && !feed_abort && tmo < 1000) begin
                    @(negedge clk);
                    acc = bus.col_ready;
                    @(posedge clk); #1;
                    tmo++;
                end
                if (!acc && !feed_abort) begin
                    checks++;
                    errors++;
                    $display("FAIL col_accept_timeout actual=%0d cycles required=<1000", tmo);
                end
            end
            for (int i = 0; i < N; i++) bus.col_data[i] = 16'hBEEF;
            bus.col_valid = !feed_abort;
            feed_done     = 1'b1;
        end
    end

    // Monitor: scoreboard pop, request-hold and done-timing checks
    initial begin
        bit          prev_stall = 1'b0;
        logic [11:0] prev_addr;
        logic [15:0] prev_data;
        word_t       w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.col_valid && bus.col_ready) begin
                    cols_acc++;
                    last_evt = cyc;
                end
                if (prev_stall) begin
                    chk("hold_write", bus.mem_write, 1'b1);
                    chk("hold_addr", bus.mem_addr, prev_addr);
                    chk("hold_data", {16'b0, bus.mem_data_write}, prev_data);
                end
                if (bus.mem_write && bus.mem_ready) begin
                    chk("write_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("wr_addr", bus.mem_addr, w.addr);
                        chk("wr_data", {16'b0, bus.mem_data_write}, {16'b0, w.data});
                    end
                    writes++;
                    last_evt = cyc;
                end
                if (bus.mem_write && !bus.mem_ready) stall_exp++;
                prev_stall = bus.mem_write && !bus.mem_ready;
                prev_addr  = bus.mem_addr;
                prev_data  = bus.mem_data_write;
                if (done) begin
                    done_cnt++;
                    chk("done_timing", cyc, last_evt + 1);
                    chk("done_no_write", bus.mem_write, 1'b0);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_col_ready", bus.col_ready, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_data", {16'b0, bus.mem_data_write}, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall_cycles, 0);
    endtask

    task automatic run_job(input int base, input int nreq, input int mode, input bit det,
                           input bit full_test, input bit restart, input int rst_after);
        int nn;
        int tmo;
        nn = (nreq > N) ? N : nreq;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                feed_cols[j][i] = det ? 16'(10 * j + i) : 16'($urandom);
        for (int j = 0; j < nn; j++)
            for (int i = 0; i < nn; i++)
                exp_q.push_back('{(base + i * nn + j) % 4096, feed_cols[j][i]});
        cols_acc   = 0;
        writes     = 0;
        done_cnt   = 0;
        stall_exp  = 0;
        ready_mode = full_test ? 3 : mode;
        feed_nn    = nn;
        feed_gaps  = !det;
        feed_abort = 1'b0;
        addr_c     = 12'(base);
        n          = 4'(nreq);
        start      = 1'b1;
        last_evt   = cyc;
        feed_go    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        addr_c = 12'($urandom);
        n      = 4'($urandom);
        @(negedge clk);
        chk("busy_after_start", busy, nn != 0);
        @(posedge clk); #1;
        if (restart) begin
            start  = 1'b1;
            addr_c = 12'd0;
            n      = 4'd2;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (full_test) begin
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk("full_cols_accepted", cols_acc, DEPTH);
            chk("full_col_ready", bus.col_ready, 1'b0);
            @(posedge clk); #1;
            ready_mode = mode;
        end
        if (rst_after > 0) begin
            tmo = 0;
            while (writes < rst_after && tmo < 1000) begin
                @(posedge clk); #1;
                tmo++;
            end
            chk("writes_before_rst", writes >= rst_after, 1'b1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst        = 1'b0;
            feed_abort = 1'b1;
            @(negedge clk);
            check_reset_outputs();
        end else begin
            tmo = 0;
            while (done_cnt == 0 && tmo < 3000) begin
                @(posedge clk); #1;
                tmo++;
            end
            repeat (3) @(posedge clk);
            #1;
            chk("done_pulses", done_cnt, 1);
            chk("queue_drained", exp_q.size(), 0);
            chk("cols_accepted", cols_acc, nn);
            chk("idle_busy", busy, 1'b0);
`ifdef DRAIN_STALL_CNT_EN
            chk("stall_cycles", stall_cycles, stall_exp);
`else
            chk("stall_cycles", stall_cycles, 0);
`endif
        end
        feed_abort = 1'b1;
        wait (feed_done);
        bus.col_valid = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        addr_c = '0;
        n      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(48, 4, 0, 1'b1, 1'b0, 1'b0, 0);    // basic, full throughput
        run_job(48, 4, 1, 1'b1, 1'b0, 1'b0, 0);    // alternate back-pressure
        run_job(48, 4, 1, 1'b1, 1'b1, 1'b0, 0);    // FIFO fills while memory is stalled
        run_job(100, 2, 0, 1'b1, 1'b0, 1'b0, 0);   // n=2
        run_job(300, 0, 0, 1'b0, 1'b0, 1'b0, 0);   // n=0
        run_job(200, 7, 2, 1'b0, 1'b0, 1'b0, 0);   // n clamped to N
        run_job(4094, 2, 1, 1'b0, 1'b0, 1'b0, 0);  // address wrap
        run_job(500, 4, 2, 1'b0, 1'b0, 1'b1, 0);   // start while busy ignored
        run_job(48, 4, 2, 1'b0, 1'b0, 1'b0, 5);    // reset after 5 writes
        run_job(48, 4, 0, 1'b1, 1'b0, 1'b0, 0);    // clean job after reset
        for (int k = 0; k < 8; k++) begin
            run_job(int'($urandom_range(4095)), int'($urandom_range(15)),
                    int'($urandom_range(2)), 1'b0, 1'b0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
